// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU codes,
// opcodes, datapath mux selects and the registered control word.
package control_pkg;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_EXEC_AUIPC,
    S_ALU_WB, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_TRAP
  } state_t;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0111;
  localparam logic [3:0] ALU_EQ     = 4'b1111;
  localparam logic [3:0] ALU_SLT    = 4'b0100;
  localparam logic [3:0] ALU_SLTU   = 4'b1100;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_XOR    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b1000;
  localparam logic [3:0] ALU_SRL    = 4'b1010;
  localparam logic [3:0] ALU_SRA    = 4'b1110;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_U      = 2'b11;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic [3:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_sel;
    logic [1:0] result_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 of R-type and I-ALU instructions to an ALU code and
// flags funct7 patterns the core does not implement.
module alu_decoder
  import control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       is_rtype,
  output logic [3:0] alu_control,
  output logic       illegal
);

  logic f7_zero;
  logic f7_alt;

  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  // For I-ALU ops other than shifts, funct7 is immediate data and is ignored.
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct3)
      3'b000: begin
        if (is_rtype && f7_alt) alu_control = ALU_SUB;
        illegal = is_rtype && !f7_zero && !f7_alt;
      end
      3'b001: begin
        alu_control = ALU_SLL;
        illegal     = !f7_zero;
      end
      3'b010: begin
        alu_control = ALU_SLT;
        illegal     = is_rtype && !f7_zero;
      end
      3'b011: begin
        alu_control = ALU_SLTU;
        illegal     = is_rtype && !f7_zero;
      end
      3'b100: begin
        alu_control = ALU_XOR;
        illegal     = is_rtype && !f7_zero;
      end
      3'b101: begin
        alu_control = f7_alt ? ALU_SRA : ALU_SRL;
        illegal     = !f7_zero && !f7_alt;
      end
      3'b110: begin
        alu_control = ALU_OR;
        illegal     = is_rtype && !f7_zero;
      end
      default: begin
        alu_control = ALU_AND;
        illegal     = is_rtype && !f7_zero;
      end
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RV32I-subset control FSM: registered Moore control word plus the
// few outputs gated live by MEM_READY and ZERO.
module control_multiciclo
  import control_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [31:0] INSTR,
  input  logic        ZERO,
  input  logic        MEM_READY,
  output logic [3:0]  ALU_CONTROL,
  output logic [1:0]  ALU_SRC_A,
  output logic [1:0]  ALU_SRC_B,
  output logic [1:0]  IMM_SEL,
  output logic [1:0]  RESULT_SRC,
  output logic        PC_WRITE,
  output logic        IR_WRITE,
  output logic        REG_WRITE,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic        ADR_SRC,
  output logic        INSTR_DONE,
  output logic        ILLEGAL
);

  state_t     state, nxt;
  ctrl_t      ctrl, ctrl_nxt;
  logic       start_q;
  logic       illegal_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] dec_alu;
  logic       dec_illegal;
  logic       fetch_done;
  logic       instr_unused;

  assign opcode       = INSTR[6:0];
  assign funct3       = INSTR[14:12];
  assign funct7       = INSTR[31:25];
  assign instr_unused = ^{INSTR[24:15], INSTR[11:7]};

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7      (funct7),
    .is_rtype    (opcode == OP_R),
    .alu_control (dec_alu),
    .illegal     (dec_illegal)
  );

  // START holds one full cycle after reset release before the first FETCH.
  always_comb begin
    nxt = state;
    case (state)
      S_START:  if (start_q) nxt = S_FETCH;
      S_FETCH:  if (MEM_READY) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:     nxt = dec_illegal ? S_TRAP : S_EXEC_R;
          OP_I:     nxt = dec_illegal ? S_TRAP : S_EXEC_I;
          OP_LW,
          OP_SW:    nxt = (funct3 == 3'b010) ? S_MEM_ADDR : S_TRAP;
          OP_BR:    nxt = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_LUI:   nxt = S_EXEC_LUI;
          OP_AUIPC: nxt = S_EXEC_AUIPC;
          default:  nxt = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_EXEC_AUIPC: nxt = S_ALU_WB;
      S_ALU_WB, S_MEM_WB, S_BRANCH:                 nxt = S_FETCH;
      S_MEM_ADDR: nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (MEM_READY) nxt = S_MEM_WB;
      S_MEM_WR:   if (MEM_READY) nxt = S_FETCH;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_START;
    endcase
  end

  // Control word for the state being entered, so it is registered with it.
  always_comb begin
    ctrl_nxt = '0;
    case (nxt)
      S_FETCH: begin
        ctrl_nxt.alu_src_a = SRCA_PC;
        ctrl_nxt.alu_src_b = SRCB_FOUR;
        ctrl_nxt.mem_read  = 1'b1;
      end
      S_DECODE: begin
        ctrl_nxt.alu_src_a = SRCA_OLDPC;
        ctrl_nxt.alu_src_b = SRCB_IMM;
        ctrl_nxt.imm_sel   = IMM_B;
      end
      S_EXEC_R: begin
        ctrl_nxt.alu_control = dec_alu;
        ctrl_nxt.alu_src_a   = SRCA_RS1;
        ctrl_nxt.alu_src_b   = SRCB_RS2;
      end
      S_EXEC_I: begin
        ctrl_nxt.alu_control = dec_alu;
        ctrl_nxt.alu_src_a   = SRCA_RS1;
        ctrl_nxt.alu_src_b   = SRCB_IMM;
        ctrl_nxt.imm_sel     = IMM_I;
      end
      S_EXEC_LUI: begin
        ctrl_nxt.alu_control = ALU_PASS_B;
        ctrl_nxt.alu_src_b   = SRCB_IMM;
        ctrl_nxt.imm_sel     = IMM_U;
      end
      S_EXEC_AUIPC: begin
        ctrl_nxt.alu_src_a = SRCA_OLDPC;
        ctrl_nxt.alu_src_b = SRCB_IMM;
        ctrl_nxt.imm_sel   = IMM_U;
      end
      S_ALU_WB: begin
        ctrl_nxt.reg_write  = 1'b1;
        ctrl_nxt.result_src = RES_ALUOUT;
        ctrl_nxt.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl_nxt.alu_src_a = SRCA_RS1;
        ctrl_nxt.alu_src_b = SRCB_IMM;
        ctrl_nxt.imm_sel   = (opcode == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEM_RD: begin
        ctrl_nxt.mem_read = 1'b1;
        ctrl_nxt.adr_src  = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_nxt.reg_write  = 1'b1;
        ctrl_nxt.result_src = RES_MDR;
        ctrl_nxt.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_nxt.mem_write = 1'b1;
        ctrl_nxt.adr_src   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_nxt.alu_control = funct3[0] ? ALU_EQ : ALU_SUB;
        ctrl_nxt.alu_src_a   = SRCA_RS1;
        ctrl_nxt.alu_src_b   = SRCB_RS2;
        ctrl_nxt.result_src  = RES_ALUOUT;
        ctrl_nxt.instr_done  = 1'b1;
      end
      default: ctrl_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= S_START;
      ctrl      <= '0;
      start_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state   <= nxt;
      ctrl    <= ctrl_nxt;
      start_q <= 1'b1;
      if (nxt == S_TRAP) illegal_q <= 1'b1;
    end
  end

  assign fetch_done  = (state == S_FETCH) && MEM_READY;

  assign ALU_CONTROL = ctrl.alu_control;
  assign ALU_SRC_A   = ctrl.alu_src_a;
  assign ALU_SRC_B   = ctrl.alu_src_b;
  assign IMM_SEL     = ctrl.imm_sel;
  assign RESULT_SRC  = fetch_done ? RES_ALU : ctrl.result_src;
  assign PC_WRITE    = fetch_done || ((state == S_BRANCH) && ZERO);
  assign IR_WRITE    = fetch_done;
  assign REG_WRITE   = ctrl.reg_write;
  assign MEM_READ    = ctrl.mem_read;
  assign MEM_WRITE   = ctrl.mem_write;
  assign ADR_SRC     = ctrl.adr_src;
  assign INSTR_DONE  = ctrl.instr_done || ((state == S_MEM_WR) && MEM_READY);
  assign ILLEGAL     = illegal_q;

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle control unit for the RV32I-subset core. Sequences fetch/decode/execute/writeback for each instruction held in the instruction register. It drives the 4-bit ALU operation code, datapath mux selects and register/memory write enables. It consumes the ALU `ZERO` flag for branch resolution and handshakes with instruction/data memory via `MEM_READY`.

## Interface
- No parameters. Encodings are fixed in `control_pkg`.
- `CLK`  in  1  system clock, rising edge.
- `RST_n`  in  1  asynchronous, active-low reset.
- `INSTR`  in  32  instruction register contents; valid from DECODE onward.
- `ZERO`  in  1  ALU zero flag (combinational from current ALU inputs).
- `MEM_READY`  in  1  memory completes the current read/write this cycle.
- `ALU_CONTROL`  out  4  ALU operation code.
- `ALU_SRC_A`  out  2  00 PC, 01 OLD_PC, 10 rs1.
- `ALU_SRC_B`  out  2  00 rs2, 01 immediate, 10 constant 4.
- `IMM_SEL`  out  2  00 I, 01 S, 10 B, 11 U.
- `RESULT_SRC`  out  2  00 ALU_OUT register, 01 memory data register, 10 live ALU result.
- `PC_WRITE`, `IR_WRITE`, `REG_WRITE`, `MEM_READ`, `MEM_WRITE`  out  1 each  enables.
- `ADR_SRC`  out  1  memory address: 0 PC, 1 ALU_OUT.
- `INSTR_DONE`  out  1  one-cycle pulse in the final state of each instruction.
- `ILLEGAL`  out  1  sticky unsupported-encoding flag.

## Operation
- ALU codes: ADD 0000, SUB 0111, EQ 1111, SLT 0100, SLTU 1100, AND 0010, OR 0001, XOR 1001, PASS_B 0110, SLL 1000, SRL 1010, SRA 1110.
- Supported opcodes:
  - R 0110011
  - I-ALU 0010011
  - LW 0000011 (funct3 010)
  - SW 0100011 (funct3 010)
  - BEQ/BNE 1100011 (funct3 000/001)
  - LUI 0110111
  - AUIPC 0010111
- funct7 rules:
  - R-type: funct7 must be 0000000, or 0100000 only with funct3 000 (SUB) or 101 (SRA).
  - I-type: SLLI/SRLI/SRAI follow the same funct7 rule; ADDI never maps to SUB.
- States and transitions:
  - START: all outputs 0 → FETCH.
  - FETCH: MEM_READ=1, ADR_SRC=0, ALU PC+4 (A=00, B=10, ADD). If MEM_READY: IR_WRITE=1, PC_WRITE=1, RESULT_SRC=10 → DECODE. Otherwise stay in FETCH with no writes.
  - DECODE: ALU OLD_PC+immB (A=01, B=01, IMM_SEL=10, ADD) latched into ALU_OUT by the datapath. Next state by opcode: R→EXEC_R; I-ALU→EXEC_I; LW/SW→MEM_ADDR; branch→BRANCH; LUI→EXEC_LUI; AUIPC→EXEC_AUIPC; anything else→TRAP.
  - EXEC_R: A=10, B=00, decoded op → ALU_WB.
  - EXEC_I: A=10, B=01, IMM_SEL=00, decoded op → ALU_WB.
  - EXEC_LUI: B=01, IMM_SEL=11, PASS_B → ALU_WB.
  - EXEC_AUIPC: A=01, B=01, IMM_SEL=11, ADD → ALU_WB.
  - ALU_WB: REG_WRITE=1, RESULT_SRC=00, INSTR_DONE=1 → FETCH.
  - MEM_ADDR: A=10, B=01, IMM_SEL 00 (LW) or 01 (SW), ADD → MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD: MEM_READ=1, ADR_SRC=1; hold until MEM_READY → MEM_WB.
  - MEM_WB: REG_WRITE=1, RESULT_SRC=01, INSTR_DONE=1 → FETCH.
  - MEM_WR: MEM_WRITE=1, ADR_SRC=1; hold until MEM_READY; in the MEM_READY cycle INSTR_DONE=1 → FETCH.
  - BRANCH: A=10, B=00, ALU SUB (BEQ) or EQ (BNE). PC_WRITE=ZERO, RESULT_SRC=00, INSTR_DONE=1 → FETCH. Taken is ZERO=1 for both BEQ and BNE, because the EQ result is 0 when the operands differ.
  - TRAP: ILLEGAL=1, all enables 0, self-loop until reset.
- Outputs are a Moore decode of state, except the MEM_READY-gated FETCH writes, MEM_WR INSTR_DONE, and the ZERO-gated BRANCH PC_WRITE.

## Timing
- Reset: async to START; every output 0 while RST_n is low. First FETCH is the second rising edge after release.
- Latencies in cycles, with 0-wait memory:
  - R / I / LUI / AUIPC: 4
  - LW: 5
  - SW: 4
  - branch: 3
- Each memory wait cycle adds one cycle.
- MEM_READ/MEM_WRITE stay asserted, with stable ADR_SRC, until the MEM_READY cycle. MEM_READY outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset mid-transaction abandons it; no enable is asserted after RST_n falls.

## Structure
- `control_pkg`: state enum, ALU code localparams, opcode constants, mux-select encodings.
- Sub-module `alu_decoder`: combinational funct3/funct7/opcode-class → ALU_CONTROL plus illegal flag, used in EXEC_R/EXEC_I.

## Test plan
- `ADD x3,x1,x2` (0x002081B3), MEM_READY=1 → ALU_CONTROL=0000 in EXEC_R; REG_WRITE and INSTR_DONE in cycle 4.
- `SUB` (0x402081B3) and `SRAI` (0x4020D193) → 0111 and 1110; `ADDI` with funct7=0100000 stays 0000.
- `BNE`, ZERO=1 → PC_WRITE=1 in BRANCH; `BEQ`, ZERO=0 → PC_WRITE=0; both finish in 3 cycles.
- `LW` with MEM_READY low for 3 cycles in MEM_RD → MEM_READ held, no REG_WRITE until MEM_WB; total 8 cycles.
- Opcode 0x7F → TRAP, ILLEGAL=1 sticky, no enables. RST_n pulse → START, ILLEGAL=0.
- RST_n dropped during MEM_WR wait → MEM_WRITE deasserts immediately; restart at START → FETCH.
